// File: rtl/abstract_cmd_encoder_pkg.sv
// Shared debug types: encoder FSM states, cmderr codes, regno ranges and
// RV32I SYSTEM-instruction field constants.
package abstract_cmd_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CMDERR_NONE      = 3'd0,
    CMDERR_NOTSUP    = 3'd2,
    CMDERR_EXCEPTION = 3'd3
  } cmderr_t;

  localparam logic [15:0] CSR_REGNO_FIRST = 16'h0000;
  localparam logic [15:0] CSR_REGNO_LAST  = 16'h0FFF;
  localparam logic [15:0] GPR_REGNO_FIRST = 16'h1000;
  localparam logic [15:0] GPR_REGNO_LAST  = 16'h101F;

  localparam logic [2:0] FUNCT3_CSRRW  = 3'b001;
  localparam logic [2:0] FUNCT3_CSRRS  = 3'b010;
  localparam logic [6:0] OPCODE_SYSTEM = 7'h73;

  localparam logic [2:0] AARSIZE_32 = 3'd2;

endpackage

// File: rtl/abstract_cmd_encoder_csr_insn_builder.sv
// Packs CSR-instruction fields into a 32-bit RV32I SYSTEM instruction word.
module csr_insn_builder
  import abstract_cmd_encoder_pkg::*;
(
  input  logic [11:0] csr,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  output logic [31:0] insn
);

  assign insn = {csr, rs1, funct3, rd, OPCODE_SYSTEM};

endmodule

// File: rtl/abstract_cmd_encoder.sv
// Turns abstract access-register commands into CSRRW/CSRRS sequences that move
// data between GPRs/CSRs and the debug scratch CSRs, then reports cmderr.
module abstract_cmd_encoder
  import abstract_cmd_encoder_pkg::*;
#(
  parameter logic [11:0] DSCRATCH0 = 12'h7B2,
  parameter logic [11:0] DSCRATCH1 = 12'h7B3,
  parameter logic [4:0]  TMP_REG   = 5'd8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_regno,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_aarsize,
  input  logic        cmd_transfer,
  output logic        insn_valid,
  output logic [31:0] insn,
  input  logic        insn_ready,
  input  logic        insn_retired,
  input  logic        insn_exception,
  output logic        resp_valid,
  output logic [2:0]  resp_err
);

  state_t      state, state_nxt;
  logic [1:0]  step, step_nxt;
  logic [1:0]  last_step, last_step_nxt;
  cmderr_t     err, err_nxt;
  logic [11:0] regno, regno_nxt;
  logic        write, write_nxt;
  logic        is_csr, is_csr_nxt;

  logic        cmd_is_csr;
  logic        cmd_is_gpr;
  logic        cmd_legal;
  logic [11:0] sel_csr;
  logic [4:0]  sel_rs1;
  logic [4:0]  sel_rd;
  logic [2:0]  sel_funct3;
  logic [31:0] built_insn;

  assign cmd_is_csr = (cmd_regno >= CSR_REGNO_FIRST) && (cmd_regno <= CSR_REGNO_LAST);
  assign cmd_is_gpr = (cmd_regno >= GPR_REGNO_FIRST) && (cmd_regno <= GPR_REGNO_LAST);
  assign cmd_legal  = (cmd_aarsize == AARSIZE_32) && (cmd_is_csr || cmd_is_gpr);

  // State and captured-command registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      step      <= 2'd0;
      last_step <= 2'd0;
      err       <= CMDERR_NONE;
      regno     <= 12'd0;
      write     <= 1'b0;
      is_csr    <= 1'b0;
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      last_step <= last_step_nxt;
      err       <= err_nxt;
      regno     <= regno_nxt;
      write     <= write_nxt;
      is_csr    <= is_csr_nxt;
    end
  end

  // Next-state and sequencing logic
  always_comb begin
    state_nxt     = state;
    step_nxt      = step;
    last_step_nxt = last_step;
    err_nxt       = err;
    regno_nxt     = regno;
    write_nxt     = write;
    is_csr_nxt    = is_csr;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          regno_nxt     = cmd_regno[11:0];
          write_nxt     = cmd_write;
          is_csr_nxt    = cmd_is_csr;
          step_nxt      = 2'd0;
          last_step_nxt = cmd_is_csr ? 2'd3 : 2'd0;
          if (!cmd_legal) begin
            err_nxt   = CMDERR_NOTSUP;
            state_nxt = ST_RESP;
          end else if (!cmd_transfer) begin
            err_nxt   = CMDERR_NONE;
            state_nxt = ST_RESP;
          end else begin
            err_nxt   = CMDERR_NONE;
            state_nxt = ST_ISSUE;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (insn_ready) begin
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // A trap mid-CSR-access still has to restore the temporary GPR
        if (insn_exception) begin
          err_nxt = CMDERR_EXCEPTION;
          if (is_csr && ((step == 2'd1) || (step == 2'd2))) begin
            step_nxt  = 2'd3;
            state_nxt = ST_ISSUE;
          end else begin
            state_nxt = ST_RESP;
          end
        end else if (insn_retired) begin
          if (step == last_step) begin
            state_nxt = ST_RESP;
          end else begin
            step_nxt  = step + 2'd1;
            state_nxt = ST_ISSUE;
          end
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Instruction field selection for the current step
  always_comb begin
    sel_csr    = DSCRATCH0;
    sel_rs1    = 5'd0;
    sel_rd     = 5'd0;
    sel_funct3 = FUNCT3_CSRRW;
    if (!is_csr) begin
      if (write) begin
        sel_rd     = regno[4:0];
        sel_funct3 = FUNCT3_CSRRS;
      end else begin
        sel_rs1 = regno[4:0];
      end
    end else begin
      case (step)
        2'd0: begin
          sel_csr = DSCRATCH1;
          sel_rs1 = TMP_REG;
        end
        2'd1: begin
          sel_csr    = write ? DSCRATCH0 : regno;
          sel_rd     = TMP_REG;
          sel_funct3 = FUNCT3_CSRRS;
        end
        2'd2: begin
          sel_csr = write ? regno : DSCRATCH0;
          sel_rs1 = TMP_REG;
        end
        2'd3: begin
          sel_csr    = DSCRATCH1;
          sel_rd     = TMP_REG;
          sel_funct3 = FUNCT3_CSRRS;
        end
        default: begin
          sel_csr = DSCRATCH1;
          sel_rd  = TMP_REG;
        end
      endcase
    end
  end

  csr_insn_builder u_builder (
    .csr    (sel_csr),
    .rs1    (sel_rs1),
    .rd     (sel_rd),
    .funct3 (sel_funct3),
    .insn   (built_insn)
  );

  // Outputs decoded from registered state only
  always_comb begin
    cmd_ready  = (state == ST_IDLE);
    insn_valid = (state == ST_ISSUE);
    resp_valid = (state == ST_RESP);
    if (state == ST_ISSUE) begin
      insn = built_insn;
    end else begin
      insn = 32'h0;
    end
    if (state == ST_RESP) begin
      resp_err = err;
    end else begin
      resp_err = 3'd0;
    end
  end

endmodule

// File: tb/tb_abstract_cmd_encoder.sv
// Directed-vector bench for abstract_cmd_encoder with hand-computed instruction words.
module tb_abstract_cmd_encoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_regno = 16'h0;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_aarsize = 3'd0;
  logic        cmd_transfer = 1'b0;
  logic        insn_valid;
  logic [31:0] insn;
  logic        insn_ready = 1'b0;
  logic        insn_retired = 1'b0;
  logic        insn_exception = 1'b0;
  logic        resp_valid;
  logic [2:0]  resp_err;

  int errors = 0;
  int checks = 0;

  abstract_cmd_encoder dut (
    .CLK            (CLK),
    .RST            (RST),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_regno      (cmd_regno),
    .cmd_write      (cmd_write),
    .cmd_aarsize    (cmd_aarsize),
    .cmd_transfer   (cmd_transfer),
    .insn_valid     (insn_valid),
    .insn           (insn),
    .insn_ready     (insn_ready),
    .insn_retired   (insn_retired),
    .insn_exception (insn_exception),
    .resp_valid     (resp_valid),
    .resp_err       (resp_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Offer one command for a single cycle; leaves the bench at the next negedge
  task automatic send_cmd(input logic [15:0] regno, input logic wr,
                          input logic [2:0] size, input logic xfer);
    cmd_regno    = regno;
    cmd_write    = wr;
    cmd_aarsize  = size;
    cmd_transfer = xfer;
    cmd_valid    = 1'b1;
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Expect one issued instruction, stall insn_ready, then retire or trap it
  task automatic do_step(input string tag, input logic [31:0] exp,
                         input int stall, input logic trap);
    check({tag, "_valid"}, {31'd0, insn_valid}, 32'd1);
    check({tag, "_insn"}, insn, exp);
    for (int i = 0; i < stall; i++) begin
      insn_retired = 1'b1;
      tick();
      insn_retired = 1'b0;
      check({tag, "_stall_valid"}, {31'd0, insn_valid}, 32'd1);
      check({tag, "_stall_insn"}, insn, exp);
    end
    insn_ready = 1'b1;
    tick();
    insn_ready = 1'b0;
    check({tag, "_wait_valid"}, {31'd0, insn_valid}, 32'd0);
    check({tag, "_wait_insn"}, insn, 32'h0);
    if (trap) insn_exception = 1'b1;
    else      insn_retired   = 1'b1;
    tick();
    insn_exception = 1'b0;
    insn_retired   = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic [2:0] err);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_resp_err"}, {29'd0, resp_err}, {29'd0, err});
    check({tag, "_no_insn"}, {31'd0, insn_valid}, 32'd0);
    tick();
    check({tag, "_resp_done"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_ready_again"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_insn_valid", {31'd0, insn_valid}, 32'd0);
    check("rst_insn", insn, 32'h0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {29'd0, resp_err}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // GPR read x5 and write x10
    send_cmd(16'h1005, 1'b0, 3'd2, 1'b1);
    do_step("gpr_rd", 32'h7B229073, 0, 1'b0);
    expect_resp("gpr_rd", 3'd0);
    send_cmd(16'h100A, 1'b1, 3'd2, 1'b1);
    do_step("gpr_wr", 32'h7B202573, 0, 1'b0);
    expect_resp("gpr_wr", 3'd0);

    // Highest GPR, then a trap on a GPR access
    send_cmd(16'h101F, 1'b0, 3'd2, 1'b1);
    do_step("gpr_x31", 32'h7B2F9073, 0, 1'b0);
    expect_resp("gpr_x31", 3'd0);
    send_cmd(16'h1005, 1'b0, 3'd2, 1'b1);
    do_step("gpr_trap", 32'h7B229073, 0, 1'b1);
    expect_resp("gpr_trap", 3'd3);

    // CSR read of mstatus with a 3-cycle stall on step 1
    send_cmd(16'h0300, 1'b0, 3'd2, 1'b1);
    do_step("csr_rd0", 32'h7B341073, 0, 1'b0);
    do_step("csr_rd1", 32'h30002473, 3, 1'b0);
    do_step("csr_rd2", 32'h7B241073, 0, 1'b0);
    do_step("csr_rd3", 32'h7B302473, 0, 1'b0);
    expect_resp("csr_rd", 3'd0);

    // CSR write of mtvec trapping on step 2; restore step still issued
    send_cmd(16'h0305, 1'b1, 3'd2, 1'b1);
    do_step("csr_wr0", 32'h7B341073, 0, 1'b0);
    do_step("csr_wr1", 32'h7B202473, 0, 1'b0);
    do_step("csr_wr2", 32'h30541073, 0, 1'b1);
    do_step("csr_wr3", 32'h7B302473, 0, 1'b0);
    expect_resp("csr_wr", 3'd3);

    // Unsupported commands and a transfer-less legal one
    send_cmd(16'h1005, 1'b0, 3'd3, 1'b1);
    expect_resp("bad_size", 3'd2);
    send_cmd(16'h2000, 1'b0, 3'd2, 1'b1);
    expect_resp("bad_regno", 3'd2);
    send_cmd(16'h1020, 1'b0, 3'd2, 1'b1);
    expect_resp("bad_gpr32", 3'd2);
    send_cmd(16'h0300, 1'b0, 3'd2, 1'b0);
    expect_resp("no_xfer", 3'd0);

    // Reset while waiting on CSR step 1
    send_cmd(16'h0300, 1'b0, 3'd2, 1'b1);
    do_step("rst_cmd0", 32'h7B341073, 0, 1'b0);
    check("rst_cmd1_insn", insn, 32'h30002473);
    insn_ready = 1'b1;
    tick();
    insn_ready = 1'b0;
    check("rst_cmd_in_wait", {31'd0, insn_valid}, 32'd0);
    RST = 1'b1;
    #1;
    check("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_mid_insn_valid", {31'd0, insn_valid}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    insn_retired = 1'b1;
    tick();
    insn_retired = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
      check("rst_idle_ready", {31'd0, cmd_ready}, 32'd1);
      tick();
    end
    send_cmd(16'h100A, 1'b1, 3'd2, 1'b1);
    do_step("post_rst", 32'h7B202573, 0, 1'b0);
    expect_resp("post_rst", 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
